icache_refill_rd: RTL and testbench

Responder side of the instruction-cache refill handshake. Accepts a line-miss request from the I-cache main controller, issues one AXI4 read burst for the whole line, and assembles the returned beats in a line buffer. Presents the complete line with a `fill_finish` pulse. Sits between the I-cache and the AXI read channels of the core's bus interface.

---
 rtl/icache_refill_rd_pkg.sv | 21 ++
 rtl/icache_refill_rd_if.sv | 39 +++
 rtl/icache_refill_rd_line_buf.sv | 26 ++
 rtl/icache_refill_rd.sv | 139 +++++++++++++
 tb/tb_icache_refill_rd.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_refill_rd_pkg.sv
// Shared types and AXI constants for the I-cache line refill reader.
package icache_refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } refill_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Clears the byte-offset-within-line bits for a line of 'words' 32-bit words.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int unsigned words);
    return addr & ~((words * 32'd4) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_refill_rd_if.sv
// Cache-side refill handshake plus AXI4 read-address/read-data channels.
interface icache_refill_rd_if #(
  parameter int unsigned LINE_WORDS = 16
);
  logic                       r_req;
  logic [31:0]                r_addr;
  logic                       r_rdy;
  logic                       r_data_ready;
  logic                       fill_finish;
  logic [32*LINE_WORDS-1:0]   fill_line;
  logic                       fill_err;

  logic [3:0]                 arid;
  logic [31:0]                araddr;
  logic [7:0]                 arlen;
  logic [2:0]                 arsize;
  logic [1:0]                 arburst;
  logic                       arvalid;
  logic                       arready;

  logic [3:0]                 rid;
  logic [31:0]                rdata;
  logic [1:0]                 rresp;
  logic                       rlast;
  logic                       rvalid;
  logic                       rready;

  modport master (
    output r_req, r_addr, r_data_ready, arready, rid, rdata, rresp, rlast, rvalid,
    input  r_rdy, fill_finish, fill_line, fill_err,
           arid, araddr, arlen, arsize, arburst, arvalid, rready
  );

  modport slave (
    input  r_req, r_addr, r_data_ready, arready, rid, rdata, rresp, rlast, rvalid,
    output r_rdy, fill_finish, fill_line, fill_err,
           arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/icache_refill_rd_line_buf.sv
// Line assembly buffer: LINE_WORDS x 32-bit registers, one indexed write per cycle.
module refill_line_buf #(
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     we_i,
  input  logic [IDX_W-1:0]         idx_i,
  input  logic [31:0]              wdata_i,
  output logic [32*LINE_WORDS-1:0] line_o
);

  logic [LINE_WORDS-1:0][31:0] words_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      words_q <= '0;
    end else if (we_i) begin
      words_q[idx_i] <= wdata_i;
    end
  end

  assign line_o = words_q;

endmodule

// File: rtl/icache_refill_rd.sv
// I-cache refill reader: one AXI4 read burst per missed line, assembled into a line buffer.
// Build option ICACHE_REFILL_CRITICAL_FIRST_EN selects a critical-word-first WRAP burst.
module icache_refill_rd
  import icache_refill_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 16,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input logic              clk,
  input logic              rstn,
  icache_refill_rd_if.slave bus
);

  localparam int unsigned      IDX_W     = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  refill_state_e    state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      req_addr;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic             arvalid, rready, r_rdy, fill_finish;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  localparam logic [1:0] AR_BURST = BURST_WRAP;
  logic [IDX_W-1:0] start_q, start_d;

  assign req_addr = {bus.r_addr[31:2], 2'b00};
  // Index addition wraps at IDX_W bits, i.e. modulo LINE_WORDS.
  assign wr_idx   = start_q + cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) start_q <= '0;
    else       start_q <= start_d;
  end
`else
  localparam logic [1:0] AR_BURST = BURST_INCR;

  assign req_addr = line_align(bus.r_addr, LINE_WORDS);
  assign wr_idx   = cnt_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
    start_d     = start_q;
`endif
    arvalid     = 1'b0;
    rready      = 1'b0;
    r_rdy       = 1'b0;
    fill_finish = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.r_req) begin
          addr_d  = req_addr;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
          start_d = bus.r_addr[IDX_W+1:2];
`endif
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        arvalid = 1'b1;
        if (bus.arready) begin
          r_rdy   = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        rready = 1'b1;
        if (bus.rvalid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          // rlast is only audited; the beat counter alone ends the burst.
          if ((bus.rresp != RESP_OKAY) || (bus.rlast != (cnt_q == LAST_BEAT))) begin
            err_d = 1'b1;
          end
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        fill_finish = 1'b1;
        if (bus.r_data_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  refill_line_buf #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W)
  ) u_line_buf (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (wr_en),
    .idx_i   (wr_idx),
    .wdata_i (bus.rdata),
    .line_o  (bus.fill_line)
  );

  assign bus.r_rdy       = r_rdy;
  assign bus.fill_finish = fill_finish;
  assign bus.fill_err    = err_q;
  assign bus.arid        = AXI_ID;
  assign bus.araddr      = addr_q;
  assign bus.arlen       = 8'(LINE_WORDS - 1);
  assign bus.arsize      = SIZE_4B;
  assign bus.arburst     = AR_BURST;
  assign bus.arvalid     = arvalid;
  assign bus.rready      = rready;

endmodule

// File: tb/tb_icache_refill_rd.sv
// Randomised self-checking bench for icache_refill_rd against a line-level reference model.
module tb_icache_refill_rd;

  localparam int unsigned LW = 16;
`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  icache_refill_rd_if #(.LINE_WORDS(LW)) bus ();

  icache_refill_rd #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] beat_data [LW];

  logic [31:0]      obs_araddr;
  logic [7:0]       obs_arlen;
  logic [2:0]       obs_arsize;
  logic [1:0]       obs_arburst;
  logic [3:0]       obs_arid;
  int               obs_rdy_cnt, obs_beats, obs_latency, obs_done_cycles, exp_gaps;
  bit               obs_rdy_bad, obs_hold_ok, obs_ar_in_done, obs_idle_arvalid, obs_timeout;
  logic [LW*32-1:0] obs_line;
  logic             obs_err;

  // Reference: beat b carries line word (start+b) mod LW, so word k came from beat (k-start) mod LW.
  function automatic logic [LW*32-1:0] model_line(input logic [31:0] addr);
    int unsigned      start;
    logic [LW*32-1:0] l;
    start = CRIT ? int'((addr / 4) % LW) : 0;
    for (int unsigned k = 0; k < LW; k++) l[k*32 +: 32] = beat_data[(k + LW - start) % LW];
    return l;
  endfunction

  function automatic logic [31:0] model_araddr(input logic [31:0] addr);
    return CRIT ? addr - (addr % 4) : addr - (addr % (LW * 4));
  endfunction

  // Plays cache + AXI slave for one refill; records what the DUT did into obs_*.
  task automatic do_burst(input logic [31:0] addr, input int ar_stall, input int gap_mode,
                          input int err_beat, input int rlast_beat, input int hold,
                          input bit already_req, input bit next_req, input logic [31:0] next_addr,
                          input int abort_beats);
    int n, ar_wait, dcyc;
    bit v, finished, drop_req, done_seen;
    n = 0; ar_wait = 0; dcyc = 0; finished = 0; drop_req = 0; done_seen = 0;
    obs_rdy_cnt = 0; obs_beats = 0; obs_latency = -1; obs_done_cycles = 0; exp_gaps = 0;
    obs_rdy_bad = 0; obs_hold_ok = 1; obs_ar_in_done = 0; obs_idle_arvalid = 1; obs_timeout = 0;
    obs_araddr = 'x; obs_arlen = 'x; obs_arsize = 'x; obs_arburst = 'x; obs_arid = 'x;
    if (!already_req) begin
      @(negedge clk);
      bus.r_req = 1'b1;
      bus.r_addr = addr;
    end
    bus.r_data_ready = (hold == 0);
    while (!finished) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        obs_timeout = 1;
        break;
      end
      if (drop_req) begin
        bus.r_req = 1'b0;
        bus.r_addr = $urandom;
        drop_req = 0;
      end
      bus.arready = bus.arvalid && (ar_wait >= ar_stall);
      if (bus.arvalid) ar_wait++;
      v = 0;
      if (bus.rready && obs_beats < LW) begin
        case (gap_mode)
          0:       v = 1;
          1:       v = (dcyc % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        dcyc++;
        if (!v) exp_gaps++;
      end
      bus.rvalid = v;
      bus.rdata  = v ? beat_data[obs_beats] : $urandom;
      bus.rresp  = (v && obs_beats == err_beat) ? 2'b10 : 2'b00;
      bus.rlast  = v && (obs_beats == rlast_beat);
      bus.rid    = 4'($urandom);
      if (bus.fill_finish) begin
        bus.r_data_ready = (obs_done_cycles >= hold);
        if (next_req) begin
          bus.r_req = 1'b1;
          bus.r_addr = next_addr;
        end
      end else begin
        bus.r_data_ready = (hold == 0);
      end
      #1;
      if (bus.r_rdy) begin
        obs_rdy_cnt++;
        if (!(bus.arvalid && bus.arready)) obs_rdy_bad = 1;
      end
      if (bus.arvalid && bus.arready) begin
        obs_araddr = bus.araddr; obs_arlen = bus.arlen; obs_arsize = bus.arsize;
        obs_arburst = bus.arburst; obs_arid = bus.arid;
        if (!bus.r_rdy) obs_rdy_bad = 1;
        drop_req = 1;
      end
      if (bus.rvalid && bus.rready) begin
        obs_beats++;
        if (abort_beats > 0 && obs_beats == abort_beats) finished = 1;
      end
      if (bus.fill_finish) begin
        if (!done_seen) begin
          obs_latency = n; obs_line = bus.fill_line; obs_err = bus.fill_err; done_seen = 1;
        end else if (bus.fill_line !== obs_line || bus.fill_err !== obs_err) begin
          obs_hold_ok = 0;
        end
        obs_done_cycles++;
        if (bus.arvalid) obs_ar_in_done = 1;
      end else if (done_seen) begin
        obs_idle_arvalid = bus.arvalid;
        finished = 1;
      end
    end
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    if (!next_req) bus.r_req = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.r_req = 0; bus.r_addr = '0; bus.r_data_ready = 1; bus.arready = 0;
    bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.rvalid = 0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got=%b exp=0", bus.arvalid); end
    n_chk++; if (bus.rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got=%b exp=0", bus.rready); end
    n_chk++; if (bus.r_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_r_rdy got=%b exp=0", bus.r_rdy); end
    n_chk++; if (bus.fill_finish !== 1'b0) begin n_fail++; $display("FAIL reset_fill_finish got=%b exp=0", bus.fill_finish); end
    n_chk++; if (bus.fill_err !== 1'b0) begin n_fail++; $display("FAIL reset_fill_err got=%b exp=0", bus.fill_err); end
    n_chk++; if (bus.fill_line !== '0) begin n_fail++; $display("FAIL reset_fill_line got=%h exp=0", bus.fill_line); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic [LW*32-1:0] exp_l;
    for (int i = 0; i < LW; i++) beat_data[i] = 32'hA0 + 32'(i);
    for (int k = 0; k < LW; k++)
      exp_l[k*32 +: 32] = CRIT ? 32'hA0 + 32'((k - 9 + LW) % LW) : 32'hA0 + 32'(k);
    do_burst(32'h1000_0024, 0, 0, -1, LW - 1, 0, 0, 0, '0, 0);
    n_chk++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got=%b exp=0", obs_timeout); end
    n_chk++; if (obs_araddr !== (CRIT ? 32'h1000_0024 : 32'h1000_0000)) begin n_fail++; $display("FAIL basic_araddr got=%h", obs_araddr); end
    n_chk++; if (obs_arlen !== 8'd15) begin n_fail++; $display("FAIL basic_arlen got=%0d exp=15", obs_arlen); end
    n_chk++; if (obs_arsize !== 3'b010) begin n_fail++; $display("FAIL basic_arsize got=%b exp=010", obs_arsize); end
    n_chk++; if (obs_arburst !== (CRIT ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL basic_arburst got=%b", obs_arburst); end
    n_chk++; if (obs_arid !== 4'd0) begin n_fail++; $display("FAIL basic_arid got=%0d exp=0", obs_arid); end
    n_chk++; if (obs_rdy_cnt !== 1 || obs_rdy_bad) begin n_fail++; $display("FAIL basic_r_rdy pulses=%0d bad=%b exp=1,0", obs_rdy_cnt, obs_rdy_bad); end
    n_chk++; if (obs_latency !== 18) begin n_fail++; $display("FAIL basic_latency got=%0d exp=18", obs_latency); end
    n_chk++; if (obs_line !== exp_l) begin n_fail++; $display("FAIL basic_line got=%h exp=%h", obs_line, exp_l); end
    n_chk++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got=%b exp=0", obs_err); end
    n_chk++; if (obs_done_cycles !== 1) begin n_fail++; $display("FAIL basic_finish_len got=%0d exp=1", obs_done_cycles); end
  endtask

  task automatic test_stalls();
    logic [31:0] a;
    a = $urandom;
    for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
    do_burst(a, 3, 1, -1, LW - 1, 0, 0, 0, '0, 0);
    n_chk++; if (obs_rdy_cnt !== 1 || obs_rdy_bad) begin n_fail++; $display("FAIL stall_r_rdy pulses=%0d bad=%b exp=1,0", obs_rdy_cnt, obs_rdy_bad); end
    n_chk++; if (obs_beats !== LW) begin n_fail++; $display("FAIL stall_beats got=%0d exp=%0d", obs_beats, LW); end
    n_chk++; if (obs_latency !== 36) begin n_fail++; $display("FAIL stall_latency got=%0d exp=36", obs_latency); end
    n_chk++; if (obs_line !== model_line(a)) begin n_fail++; $display("FAIL stall_line got=%h exp=%h", obs_line, model_line(a)); end
    n_chk++; if (obs_araddr !== model_araddr(a)) begin n_fail++; $display("FAIL stall_araddr got=%h exp=%h", obs_araddr, model_araddr(a)); end
  endtask

  task automatic test_errors();
    logic [31:0] a;
    a = $urandom;
    for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
    do_burst(a, 0, 0, 5, LW - 1, 0, 0, 0, '0, 0);
    n_chk++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL err_slverr got=%b exp=1", obs_err); end
    n_chk++; if (obs_line !== model_line(a)) begin n_fail++; $display("FAIL err_slverr_line got=%h exp=%h", obs_line, model_line(a)); end
    do_burst(a, 0, 0, -1, 10, 0, 0, 0, '0, 0);
    n_chk++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL err_early_rlast got=%b exp=1", obs_err); end
    n_chk++; if (obs_beats !== LW || obs_latency !== 18) begin n_fail++; $display("FAIL err_early_rlast_len beats=%0d lat=%0d exp=%0d,18", obs_beats, obs_latency, LW); end
    do_burst(a, 0, 0, -1, -1, 0, 0, 0, '0, 0);
    n_chk++; if (obs_err !== 1'b1) begin n_fail++; $display("FAIL err_missing_rlast got=%b exp=1", obs_err); end
    do_burst(a, 0, 0, -1, LW - 1, 0, 0, 0, '0, 0);
    n_chk++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got=%b exp=0", obs_err); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    a = $urandom;
    for (int i = 0; i < LW; i++) beat_data[i] = $urandom | 32'h1;
    do_burst(a, 0, 0, -1, LW - 1, 0, 0, 0, '0, 7);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_chk++; if (bus.rready !== 1'b0) begin n_fail++; $display("FAIL rstmid_rready got=%b exp=0", bus.rready); end
    n_chk++; if (bus.fill_finish !== 1'b0) begin n_fail++; $display("FAIL rstmid_fill_finish got=%b exp=0", bus.fill_finish); end
    n_chk++; if (bus.fill_line !== '0) begin n_fail++; $display("FAIL rstmid_fill_line got=%h exp=0", bus.fill_line); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    a = $urandom;
    for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
    do_burst(a, 0, 0, -1, LW - 1, 0, 0, 0, '0, 0);
    n_chk++; if (obs_latency !== 18) begin n_fail++; $display("FAIL rstmid_latency got=%0d exp=18", obs_latency); end
    n_chk++; if (obs_line !== model_line(a)) begin n_fail++; $display("FAIL rstmid_line got=%h exp=%h", obs_line, model_line(a)); end
    n_chk++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err got=%b exp=0", obs_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
    do_burst(a, 0, 0, -1, LW - 1, 4, 0, 1, b, 0);
    n_chk++; if (obs_done_cycles !== 5) begin n_fail++; $display("FAIL b2b_hold_len got=%0d exp=5", obs_done_cycles); end
    n_chk++; if (obs_hold_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_hold_stable got=%b exp=1", obs_hold_ok); end
    n_chk++; if (obs_line !== model_line(a)) begin n_fail++; $display("FAIL b2b_line1 got=%h exp=%h", obs_line, model_line(a)); end
    n_chk++; if (obs_ar_in_done !== 1'b0 || obs_idle_arvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_early_accept done=%b idle=%b exp=0,0", obs_ar_in_done, obs_idle_arvalid); end
    for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
    do_burst(b, 0, 0, -1, LW - 1, 0, 1, 0, '0, 0);
    n_chk++; if (obs_latency !== 18) begin n_fail++; $display("FAIL b2b_latency2 got=%0d exp=18", obs_latency); end
    n_chk++; if (obs_araddr !== model_araddr(b)) begin n_fail++; $display("FAIL b2b_araddr2 got=%h exp=%h", obs_araddr, model_araddr(b)); end
    n_chk++; if (obs_line !== model_line(b)) begin n_fail++; $display("FAIL b2b_line2 got=%h exp=%h", obs_line, model_line(b)); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int stall, gm, eb, lb;
    bit exp_err;
    for (int it = 0; it < 10; it++) begin
      a = $urandom;
      for (int i = 0; i < LW; i++) beat_data[i] = $urandom;
      stall = $urandom_range(0, 3);
      gm = ($urandom_range(0, 1) == 0) ? 0 : 2;
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LW - 1) : -1;
      case ($urandom_range(0, 5))
        0:       lb = $urandom_range(0, LW - 2);
        1:       lb = -1;
        default: lb = LW - 1;
      endcase
      exp_err = (eb >= 0) || (lb != LW - 1);
      do_burst(a, stall, gm, eb, lb, 0, 0, 0, '0, 0);
      n_chk++; if (obs_araddr !== model_araddr(a)) begin n_fail++; $display("FAIL rand%0d_araddr got=%h exp=%h", it, obs_araddr, model_araddr(a)); end
      n_chk++; if (obs_line !== model_line(a)) begin n_fail++; $display("FAIL rand%0d_line got=%h exp=%h", it, obs_line, model_line(a)); end
      n_chk++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL rand%0d_err got=%b exp=%b", it, obs_err, exp_err); end
      n_chk++; if (obs_latency !== int'(LW) + 2 + stall + exp_gaps) begin n_fail++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, obs_latency, int'(LW) + 2 + stall + exp_gaps); end
      n_chk++; if (obs_timeout !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout got=%b exp=0", it, obs_timeout); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
